// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer
// Initiator side of a WIDTH-bit ALU interface. Host commands {opcode, A, B}
// enter a DEPTH-entry FIFO. A three-state FSM pops one command at a time.
// It either presents the operands to the ALU for ALU_LAT+1 cycles and then
// captures the result, or it answers locally (RST / undefined opcodes). The
// response is held on a valid/ready port until the host accepts it.
//
// Ports
//   clk, rst_n                 clock, async active-low reset
//   cmd_valid_i / cmd_ready_o  host command handshake (ready = FIFO not full)
//   cmd_opcode_i, cmd_a_i, cmd_b_i   command fields
//   alu_a_o, alu_b_o, alu_opcode_o   registered ALU operands / opcode
//   alu_result_i               ALU result, sampled ALU_LAT cycles after issue
//   res_valid_o / res_ready_i  response handshake
//   res_data_o, res_opcode_o, res_err_o  response payload
//   fifo_count_o               FIFO occupancy
//   busy_o                     FSM not idle or FIFO not empty
module alu_cmd_sequencer #(
  parameter int WIDTH   = 16,
  parameter int DEPTH   = 4,
  parameter int ALU_LAT = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cmd_valid_i,
  output logic                     cmd_ready_o,
  input  logic [3:0]               cmd_opcode_i,
  input  logic [WIDTH-1:0]         cmd_a_i,
  input  logic [WIDTH-1:0]         cmd_b_i,
  output logic [WIDTH-1:0]         alu_a_o,
  output logic [WIDTH-1:0]         alu_b_o,
  output logic [3:0]               alu_opcode_o,
  input  logic [WIDTH-1:0]         alu_result_i,
  output logic                     res_valid_o,
  input  logic                     res_ready_i,
  output logic [WIDTH-1:0]         res_data_o,
  output logic [3:0]               res_opcode_o,
  output logic                     res_err_o,
  output logic [$clog2(DEPTH):0]   fifo_count_o,
  output logic                     busy_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [2:0] LAT_C = ALU_LAT[2:0];

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    CL_EXEC  = 2'd0,
    CL_NOP   = 2'd1,
    CL_LOCAL = 2'd2,
    CL_UNDEF = 2'd3
  } op_class_t;

  // Opcodes not listed explicitly are undefined and answered with err=1.
  function automatic op_class_t classify(input logic [3:0] op);
    op_class_t c;
    case (op)
      4'b0100, 4'b0101, 4'b1000, 4'b1001,
      4'b1010, 4'b1011, 4'b1100, 4'b1101: c = CL_EXEC;
      4'b0000:                            c = CL_NOP;
      4'b0001:                            c = CL_LOCAL;
      default:                            c = CL_UNDEF;
    endcase
    return c;
  endfunction

  // FIFO storage and pointers
  logic [3:0]       op_mem_q [DEPTH];
  logic [WIDTH-1:0] a_mem_q  [DEPTH];
  logic [WIDTH-1:0] b_mem_q  [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q,  count_d;

  // FSM and datapath registers
  state_t           state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [3:0]       alu_op_q, alu_op_d;
  logic             res_valid_q, res_valid_d;
  logic [WIDTH-1:0] res_data_q, res_data_d;
  logic [3:0]       res_op_q, res_op_d;
  logic             res_err_q, res_err_d;

  logic             push_s;
  logic             pop_s;
  logic             full_s;
  logic             empty_s;
  logic [3:0]       head_op_s;
  logic [WIDTH-1:0] head_a_s;
  logic [WIDTH-1:0] head_b_s;
  op_class_t        head_cls_s;

  assign full_s     = (count_q == CW'(DEPTH));
  assign empty_s    = (count_q == CW'(0));
  assign push_s     = cmd_valid_i && !full_s;
  assign head_op_s  = op_mem_q[rd_ptr_q];
  assign head_a_s   = a_mem_q[rd_ptr_q];
  assign head_b_s   = b_mem_q[rd_ptr_q];
  assign head_cls_s = classify(head_op_s);

  // FIFO storage write; contents need no reset since count gates reads
  always_ff @(posedge clk) begin
    if (push_s) begin
      op_mem_q[wr_ptr_q] <= cmd_opcode_i;
      a_mem_q[wr_ptr_q]  <= cmd_a_i;
      b_mem_q[wr_ptr_q]  <= cmd_b_i;
    end
  end

  // FIFO pointer and occupancy next-state; DEPTH is a power of 2 so pointers wrap naturally
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // FSM next-state and datapath loads
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_op_d    = alu_op_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_op_d    = res_op_q;
    res_err_d   = res_err_q;
    pop_s       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty_s) begin
          pop_s = 1'b1;
          case (head_cls_s)
            CL_EXEC: begin
              alu_a_d  = head_a_s;
              alu_b_d  = head_b_s;
              alu_op_d = head_op_s;
              cnt_d    = 3'd0;
              state_d  = S_EXEC;
            end
            CL_LOCAL, CL_UNDEF: begin
              res_data_d  = '0;
              res_op_d    = head_op_s;
              res_err_d   = (head_cls_s == CL_UNDEF);
              res_valid_d = 1'b1;
              state_d     = S_RESP;
            end
            default: begin
              // NOP: dropped, the next entry may pop on the following edge
              state_d = S_IDLE;
            end
          endcase
        end else begin
          state_d = S_IDLE;
        end
      end
      S_EXEC: begin
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == LAT_C) begin
          res_data_d  = alu_result_i;
          res_op_d    = alu_op_q;
          res_err_d   = 1'b0;
          res_valid_d = 1'b1;
          alu_op_d    = 4'b0000;
          state_d     = S_RESP;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_RESP: begin
        if (res_ready_i) begin
          res_valid_d = 1'b0;
          state_d     = S_IDLE;
        end else begin
          state_d = S_RESP;
        end
      end
      default: begin
        state_d     = S_IDLE;
        alu_op_d    = 4'b0000;
        res_valid_d = 1'b0;
      end
    endcase
  end

  // State, FIFO control and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      state_q     <= S_IDLE;
      cnt_q       <= 3'd0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= 4'b0000;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_op_q    <= 4'b0000;
      res_err_q   <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_op_q    <= alu_op_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_op_q    <= res_op_d;
      res_err_q   <= res_err_d;
    end
  end

  assign cmd_ready_o  = !full_s;
  assign alu_a_o      = alu_a_q;
  assign alu_b_o      = alu_b_q;
  assign alu_opcode_o = alu_op_q;
  assign res_valid_o  = res_valid_q;
  assign res_data_o   = res_data_q;
  assign res_opcode_o = res_op_q;
  assign res_err_o    = res_err_q;
  assign fifo_count_o = count_q;
  assign busy_o       = (state_q != S_IDLE) || !empty_s;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
module tb_alu_cmd_sequencer;

  localparam int W   = 16;
  localparam int D   = 4;
  localparam int LAT = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [3:0]    cmd_opcode = 4'h0;
  logic [W-1:0]  cmd_a = '0, cmd_b = '0;
  logic [W-1:0]  alu_a, alu_b, alu_result;
  logic [3:0]    alu_opcode;
  logic          res_valid;
  logic          res_ready = 1'b1;
  logic [W-1:0]  res_data;
  logic [3:0]    res_opcode;
  logic          res_err;
  logic [2:0]    fifo_count;
  logic          busy;

  // second instance: combinational ALU, latency 0
  logic          c0_valid = 1'b0;
  logic          c0_ready;
  logic [3:0]    c0_op = 4'h0;
  logic [W-1:0]  c0_a = '0, c0_b = '0;
  logic [W-1:0]  a0, b0, r0, rd0;
  logic [3:0]    op0, rop0;
  logic          rv0, rerr0, busy0;
  logic [2:0]    cnt0;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [W-1:0] d;
    logic [3:0]   op;
    logic         e;
  } resp_t;
  resp_t exp_q[$];

  function automatic logic [W-1:0] alu_f(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    case (op)
      4'h4: return a + b;
      4'h5: return a - b;
      4'h8: return a & b;
      4'h9: return a | b;
      4'hA: return a ^ b;
      4'hB: return ~(a & b);
      4'hC: return ~(a | b);
      4'hD: return ~a;
      default: return '0;
    endcase
  endfunction

  function automatic bit is_exec(input logic [3:0] op);
    return op inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD};
  endfunction

  // one-stage pipelined ALU: result is valid LAT=1 cycle after operands
  logic [W-1:0] alu_res_q = '0;
  always @(posedge clk) alu_res_q <= alu_f(alu_opcode, alu_a, alu_b);
  assign alu_result = alu_res_q;
  assign r0 = alu_f(op0, a0, b0);

  alu_cmd_sequencer #(.WIDTH(W), .DEPTH(D), .ALU_LAT(LAT)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_opcode_i(cmd_opcode), .cmd_a_i(cmd_a), .cmd_b_i(cmd_b),
    .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_opcode_o(alu_opcode),
    .alu_result_i(alu_result),
    .res_valid_o(res_valid), .res_ready_i(res_ready),
    .res_data_o(res_data), .res_opcode_o(res_opcode), .res_err_o(res_err),
    .fifo_count_o(fifo_count), .busy_o(busy)
  );

  alu_cmd_sequencer #(.WIDTH(W), .DEPTH(D), .ALU_LAT(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid_i(c0_valid), .cmd_ready_o(c0_ready),
    .cmd_opcode_i(c0_op), .cmd_a_i(c0_a), .cmd_b_i(c0_b),
    .alu_a_o(a0), .alu_b_o(b0), .alu_opcode_o(op0),
    .alu_result_i(r0),
    .res_valid_o(rv0), .res_ready_i(1'b1),
    .res_data_o(rd0), .res_opcode_o(rop0), .res_err_o(rerr0),
    .fifo_count_o(cnt0), .busy_o(busy0)
  );

  // res_ready driver: random or fixed level, updated just after each edge
  bit rr_rand = 1'b0;
  bit rr_val  = 1'b1;
  always @(posedge clk) begin
    #2;
    res_ready = rr_rand ? 1'($urandom_range(0, 1)) : rr_val;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // reference model: what the host should eventually see for one accepted command
  task automatic push_model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    resp_t r;
    if (op == 4'h0) return;
    if (is_exec(op))       r = '{d: alu_f(op, a, b), op: op, e: 1'b0};
    else if (op == 4'h1)   r = '{d: '0, op: op, e: 1'b0};
    else                   r = '{d: '0, op: op, e: 1'b1};
    exp_q.push_back(r);
  endtask

  task automatic send_once(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b, output bit acc);
    cmd_valid  = 1'b1;
    cmd_opcode = op;
    cmd_a      = a;
    cmd_b      = b;
    acc        = cmd_ready;
    if (acc) push_model(op, a, b);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic send(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    bit acc;
    int tries = 0;
    do begin
      send_once(op, a, b, acc);
      tries++;
    end while (!acc && tries < 200);
    if (!acc) begin
      checks++; errors++;
      $display("FAIL send_timeout: cmd_ready stayed 0 for op %0h", op);
    end
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_queue_empty"}, exp_q.size(), 0);
    chk({name, "_not_busy"}, {31'd0, busy}, 0);
  endtask

  // monitor: scoreboard compare, response stability, ALU operand hold
  bit           stalled = 1'b0;
  resp_t        prev_r;
  int           run = 0;
  logic [W-1:0] ra, rb;
  logic [3:0]   ro;
  always @(negedge clk) begin
    if (!rst_n) begin
      stalled = 1'b0;
      run = 0;
    end else begin
      if (res_valid) begin
        if (stalled) begin
          checks++;
          if ({res_data, res_opcode, res_err} !== prev_r) begin
            errors++;
            $display("FAIL res_stable: got %0h/%0h/%0b held %0h/%0h/%0b",
                     res_data, res_opcode, res_err, prev_r.d, prev_r.op, prev_r.e);
          end
        end
        if (res_ready) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_resp: got %0h/%0h/%0b with none expected", res_data, res_opcode, res_err);
          end else begin
            resp_t e;
            e = exp_q.pop_front();
            if ({res_data, res_opcode, res_err} !== e) begin
              errors++;
              $display("FAIL resp: got data %0h op %0h err %0b expected data %0h op %0h err %0b",
                       res_data, res_opcode, res_err, e.d, e.op, e.e);
            end
          end
        end
        stalled = !res_ready;
        prev_r  = '{d: res_data, op: res_opcode, e: res_err};
      end else begin
        stalled = 1'b0;
      end
      if (alu_opcode != 4'h0) begin
        if (!is_exec(alu_opcode)) begin
          checks++; errors++;
          $display("FAIL alu_op_legal: got %0h", alu_opcode);
        end
        if (run == 0) begin
          ra = alu_a; rb = alu_b; ro = alu_opcode;
        end else if (alu_a !== ra || alu_b !== rb || alu_opcode !== ro) begin
          checks++; errors++;
          $display("FAIL operand_hold: got %0h %0h %0h expected %0h %0h %0h", alu_a, alu_b, alu_opcode, ra, rb, ro);
        end
        run++;
      end else if (run != 0) begin
        chk("operand_cycles", run, LAT + 1);
        run = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, got %0d checks", checks);
    $fatal(1, "timeout");
  end

  initial begin
    bit acc;
    int nz;
    bit got;
    logic [W-1:0] gd;
    logic [3:0] gop;
    logic ge;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_fifo_count", fifo_count, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_alu", {alu_a, alu_b, alu_opcode}, 0);
    chk("rst_res", {res_data, res_opcode, res_err}, 0);
    chk("rst_busy", busy, 0);

    // latency-0 instance: AND, operands held exactly one cycle
    @(posedge clk); #1;
    c0_valid = 1'b1; c0_op = 4'h8; c0_a = 16'hF0F0; c0_b = 16'h3C3C;
    @(posedge clk); #1;
    c0_valid = 1'b0;
    nz = 0; got = 1'b0; gd = '0; gop = '0; ge = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (op0 != 4'h0) nz++;
      if (rv0 && !got) begin
        got = 1'b1; gd = rd0; gop = rop0; ge = rerr0;
      end
    end
    chk("lat0_operand_cycles", nz, 1);
    chk("lat0_got_resp", got, 1);
    chk("lat0_data", gd, 16'h3030);
    chk("lat0_opcode", gop, 4'h8);
    chk("lat0_err", ge, 0);

    // ADD timing relative to the accepting edge
    @(posedge clk); #1;
    send(4'h4, 16'h1234, 16'h0FFF);
    @(negedge clk);
    chk("add_c1_alu_op", alu_opcode, 4'h0);
    chk("add_c1_count", fifo_count, 1);
    @(negedge clk);
    chk("add_c2_alu_op", alu_opcode, 4'h4);
    @(negedge clk);
    chk("add_c3_alu_op", alu_opcode, 4'h4);
    @(negedge clk);
    chk("add_c4_res_valid", res_valid, 1);
    chk("add_c4_alu_op", alu_opcode, 4'h0);
    drain("add");

    // SUB underflow then NOT; NOP / undefined / RST
    @(posedge clk); #1;
    send(4'h5, 16'h0000, 16'h0001);
    send(4'hD, 16'h00FF, 16'h0000);
    drain("sub_not");
    @(posedge clk); #1;
    send(4'h0, 16'h1111, 16'h2222);
    send(4'h7, 16'h3333, 16'h4444);
    send(4'h1, 16'h5555, 16'h6666);
    drain("local");

    // random traffic with random back-pressure
    rr_rand = 1'b1;
    for (int i = 0; i < 150; i++) begin
      logic [3:0] op;
      logic [W-1:0] a, b;
      op = 4'($urandom_range(0, 15));
      a  = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
      b  = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
      send(op, a, b);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    drain("random");
    rr_rand = 1'b0;

    // FIFO full while the response is stalled
    rr_val = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    send(4'h4, 16'h0101, 16'h0202);
    for (int i = 0; i < 4; i++) send(4'h9, 16'($urandom), 16'($urandom));
    @(negedge clk);
    chk("full_count", fifo_count, 4);
    chk("full_cmd_ready", cmd_ready, 0);
    chk("full_res_valid", res_valid, 1);
    @(posedge clk); #1;
    send_once(4'hA, 16'hAAAA, 16'h5555, acc);
    chk("full_6th_rejected", acc, 0);
    repeat (4) @(posedge clk);
    #1 rr_val = 1'b1;
    send(4'hA, 16'hAAAA, 16'h5555);
    drain("full");

    // reset mid-EXEC with two commands queued
    @(posedge clk); #1;
    send(4'h4, 16'h0007, 16'h0008);
    send(4'h5, 16'h0009, 16'h0001);
    send(4'h8, 16'h00FF, 16'h0F0F);
    chk("pre_rst_alu_op", alu_opcode, 4'h4);
    chk("pre_rst_count", fifo_count, 2);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_alu", {alu_a, alu_b, alu_opcode}, 0);
    chk("async_rst_res", {res_valid, res_data, res_opcode, res_err}, 0);
    chk("async_rst_count", fifo_count, 0);
    chk("async_rst_ready", cmd_ready, 1);
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_count", fifo_count, 0);
    chk("post_rst_no_resp", res_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
